clk_reset_sequencer: RTL
========================

// Module: clk_reset_sequencer
// PURPOSE
//  Reset/bring-up sequencer fed by the PLL's main system clock (o_ck0, 80 MHz).
//  Holds core logic in reset until the 12 MHz reference proves alive and stable.
//  Then releases the core reset, times the SDRAM 100 us power-up wait, and
//  pulses the SDRAM controller's init start. A watchdog on a reference-domain
//  toggle re-asserts reset if the reference stalls, i.e. the PLL is unreliable.
// PARAMETERS
//  STABLE_CYCLES   1024   cycles of healthy reference before core reset release
//  POWERUP_CYCLES  8000   cycles from release to SDRAM init pulse (100 us @80 MHz)
//  WD_CYCLES       64     max cycles between reference toggle edges before stall
// PORTS
//  i_clk         in   1  system clock (PLL o_ck0)
//  i_reset       in   1  synchronous, active-high reset
//  i_ref_toggle  in   1  async; inverted every reference clock cycle in 12 MHz domain
//  o_reset       out  1  registered core reset, active high
//  o_sdram_go    out  1  one-cycle pulse: start SDRAM init sequence
//  o_ready       out  1  high while in S_RUN
//  o_fault_cnt   out  8  stall events since i_reset, saturates at 255
// BEHAVIOUR
//  - One clock (i_clk); reset is synchronous and active-high on i_reset; all
//    flops update on posedge i_clk.
//  - On i_reset: state=S_HOLD, o_reset=1, o_sdram_go=0, o_ready=0,
//    o_fault_cnt=0, cnt=0, wd=0. Synchronizer flops also clear to 0.
//  - Sync/edge: 2-FF synchronizer on i_ref_toggle plus a 3rd FF.
//    edge = ff2^ff3, giving 3 cycles from input change to edge.
//  - Watchdog wd, width $clog2(WD_CYCLES+1): cleared on edge, else +1,
//    saturating at WD_CYCLES. stall = (wd==WD_CYCLES).
//  - FSM, all outputs registered (visible one cycle after transition decision):
//    S_HOLD:   o_reset=1, cnt=0; on edge -> S_STABLE.
//    S_STABLE: o_reset=1; cnt++; stall -> S_HOLD, fault++;
//              cnt==STABLE_CYCLES-1 -> S_PWRUP, cnt=0.
//    S_PWRUP:  o_reset=0; cnt++; stall -> S_HOLD, fault++;
//              cnt==POWERUP_CYCLES-1 -> S_RUN, o_sdram_go=1 for exactly 1 cycle.
//    S_RUN:    o_reset=0, o_ready=1; stall -> S_HOLD, fault++; o_ready=0 and
//              o_reset=1 on the next cycle.
//  - Stall has priority over a same-cycle count completion. No go pulse then.
//  - o_sdram_go never asserts outside the S_PWRUP->S_RUN transition.
//  - o_fault_cnt increments once per stall-induced exit from STABLE/PWRUP/RUN.
//    It holds at 255. Stall while in S_HOLD is not a fault.
//  - Stall stays asserted until an edge. Back in S_HOLD, first edge restarts the sequence.
//  - i_reset mid-sequence (any state) aborts: next cycle equals reset values.
//  - cnt width $clog2(max(STABLE_CYCLES,POWERUP_CYCLES)). No wrap is reachable.
// TESTING (bench uses STABLE_CYCLES=16, POWERUP_CYCLES=32, WD_CYCLES=8)
//  1 Toggle every 6 cycles from reset release -> o_reset falls 16 cycles after
//    leaving S_HOLD; o_sdram_go single pulse 32 cycles later; o_ready=1 after.
//  2 In S_RUN stop toggling -> 8 cycles after last edge o_reset=1, o_ready=0,
//    o_fault_cnt=1; resume toggling -> full sequence repeats, one more go pulse.
//  3 Stall during S_STABLE at cnt=10 -> back to S_HOLD, o_reset never drops,
//    no go pulse, o_fault_cnt=1.
//  4 Stall on the same cycle cnt hits 31 in S_PWRUP -> S_HOLD, no o_sdram_go.
//  5 Assert i_reset for 1 cycle in S_PWRUP at cnt=20 -> o_reset=1,
//    o_fault_cnt=0, no go pulse; sequence restarts on next edge.
//  6 Force 300 stall cycles from S_STABLE (toggle in bursts) -> o_fault_cnt
//    saturates at 255.

Source files
------------

// File: rtl/clk_reset_sequencer.sv
// Bring-up sequencer: holds core reset until the reference toggle proves alive,
// times the SDRAM power-up wait, pulses init start, and re-enters reset on stall.
module clk_reset_sequencer #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int POWERUP_CYCLES = 8000,
    parameter int WD_CYCLES      = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ref_toggle,
    output logic       o_reset,
    output logic       o_sdram_go,
    output logic       o_ready,
    output logic [7:0] o_fault_cnt
);

    localparam int CNT_MAX = (STABLE_CYCLES > POWERUP_CYCLES) ? STABLE_CYCLES : POWERUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int WD_W    = $clog2(WD_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT    = WD_W'(WD_CYCLES);

    typedef enum logic [1:0] {
        S_HOLD,
        S_STABLE,
        S_PWRUP,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [7:0]       fault_q, fault_d;
    logic             reset_q, reset_d;
    logic             go_q, go_d;
    logic             ready_q, ready_d;
    logic [2:0]       sync_q, sync_d;
    logic             ref_edge;
    logic             stall;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bits [1:0] form the metastability synchronizer; bit 2 is the edge-detect delay.
    assign sync_d   = {sync_q[1:0], i_ref_toggle};
    assign ref_edge = sync_q[1] ^ sync_q[2];
    assign stall    = (wd_q == WD_LIMIT);

    always_comb begin
        wd_d = wd_q;
        if (ref_edge) begin
            wd_d = '0;
        end else if (!stall) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        go_d    = 1'b0;
        case (state_q)
            S_HOLD: begin
                cnt_d = '0;
                if (ref_edge) begin
                    state_d = S_STABLE;
                end
            end
            S_STABLE: begin
                if (stall) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    fault_d = sat_inc8(fault_q);
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_PWRUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PWRUP: begin
                // A stall on the completion cycle wins, so no go pulse escapes.
                if (stall) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    fault_d = sat_inc8(fault_q);
                end else if (cnt_q == PWRUP_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    go_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (stall) begin
                    state_d = S_HOLD;
                    fault_d = sat_inc8(fault_q);
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
        reset_d = (state_d == S_HOLD) || (state_d == S_STABLE);
        ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            wd_q    <= '0;
            fault_q <= '0;
            reset_q <= 1'b1;
            go_q    <= 1'b0;
            ready_q <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
            reset_q <= reset_d;
            go_q    <= go_d;
            ready_q <= ready_d;
            sync_q  <= sync_d;
        end
    end

    assign o_reset     = reset_q;
    assign o_sdram_go  = go_q;
    assign o_ready     = ready_q;
    assign o_fault_cnt = fault_q;

endmodule
